// File: rtl/main_mem_responder.sv
// Main-memory responder for a cache controller: single-outstanding request
// handshake with a fixed latency, one-cycle status strobe and word storage.
module main_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmem_r,
  input  logic        mmem_w,
  input  logic [31:0] mmem_addr,
  input  logic [31:0] mmem_wdata,
  output logic [31:0] mmem_rdata,
  output logic        mmem_status,
  output logic        busy
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    RELEASE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [IW-1:0] idx;
  logic [31:0] wdata_q;
  logic        op_write;
  logic        req;
  logic        accept;
  logic [31:0] mem [DEPTH_WORDS];

  // Byte-offset bits and bits above the word index are intentionally dropped.
  logic addr_unused;
  assign addr_unused = ^{mmem_addr[31:IW+2], mmem_addr[1:0]};

  assign req    = mmem_r | mmem_w;
  assign accept = (state == IDLE) && req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = WAIT;
      // Dropping the request aborts even on the final WAIT cycle.
      WAIT:    if (!req) state_nxt = IDLE;
               else if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = RELEASE;
      RELEASE: if (!req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mmem_status = (state == DONE);
    busy        = (state != IDLE);
    mmem_rdata  = '0;
    if (state == DONE && !op_write) mmem_rdata = mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
    end else if (accept) begin
      cnt      <= 4'(LATENCY - 1);
      idx      <= mmem_addr[IW+1:2];
      wdata_q  <= mmem_wdata;
      op_write <= mmem_w;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Storage has no reset; commit happens on the edge leaving DONE, which a
  // reset or an abort can never reach.
  always_ff @(posedge clk) begin
    if (state == DONE && op_write) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed plus randomized bench for main_mem_responder against a
// transaction-level memory model.
module tb_main_mem_responder;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmem_r = 1'b0, mmem_w = 1'b0;
  logic [31:0] mmem_addr = '0, mmem_wdata = '0;
  logic [31:0] mmem_rdata;
  logic        mmem_status, busy;

  logic        r1 = 1'b0, w1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        status1, busy1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model [int unsigned];

  main_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mmem_r(mmem_r), .mmem_w(mmem_w),
    .mmem_addr(mmem_addr), .mmem_wdata(mmem_wdata),
    .mmem_rdata(mmem_rdata), .mmem_status(mmem_status), .busy(busy)
  );

  main_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mmem_r(r1), .mmem_w(w1),
    .mmem_addr(addr1), .mmem_wdata(wdata1),
    .mmem_rdata(rdata1), .mmem_status(status1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned widx(input logic [31:0] a, input int unsigned depth);
    return (a / 4) % depth;
  endfunction

  function automatic logic [31:0] mread(input int unsigned i);
    return model.exists(i) ? model[i] : 32'h0;
  endfunction

  // op: 0 read, 1 write, 2 read+write (write wins). hold: cycles request
  // stays high after the status cycle.
  task automatic txn(input int op, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input string tag);
    int unsigned i = widx(a, DEPTH);
    logic [31:0] exp_rd = (op == 0) ? mread(i) : 32'h0;
    chk1($sformatf("%s_idle", tag), busy, 1'b0);
    mmem_r = (op != 1); mmem_w = (op != 0);
    mmem_addr = a; mmem_wdata = d;
    tick();
    mmem_addr = $urandom; mmem_wdata = $urandom;
    chk1($sformatf("%s_acc_busy", tag), busy, 1'b1);
    for (int k = 1; k <= int'(LAT); k++) begin
      tick();
      if (k < int'(LAT)) begin
        chk1($sformatf("%s_wait_status", tag), mmem_status, 1'b0);
        chk($sformatf("%s_wait_rdata", tag), mmem_rdata, 32'h0);
      end else begin
        chk1($sformatf("%s_status", tag), mmem_status, 1'b1);
        chk($sformatf("%s_rdata", tag), mmem_rdata, exp_rd);
      end
    end
    if (op != 0) model[i] = d;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk1($sformatf("%s_hold_status", tag), mmem_status, 1'b0);
      chk1($sformatf("%s_hold_busy", tag), busy, 1'b1);
    end
    mmem_r = 1'b0; mmem_w = 1'b0;
    if (hold == 0) begin
      tick();
      chk1($sformatf("%s_release_busy", tag), busy, 1'b1);
    end
    tick();
    chk1($sformatf("%s_end_busy", tag), busy, 1'b0);
    chk1($sformatf("%s_end_status", tag), mmem_status, 1'b0);
  endtask

  // Request dropped after two WAIT cycles: no strobe, no commit.
  task automatic abort_txn(input int op, input logic [31:0] a, input logic [31:0] d,
                           input string tag);
    mmem_r = (op == 0); mmem_w = (op != 0);
    mmem_addr = a; mmem_wdata = d;
    tick();
    tick();
    chk1($sformatf("%s_busy", tag), busy, 1'b1);
    mmem_r = 1'b0; mmem_w = 1'b0;
    tick();
    chk1($sformatf("%s_abort_busy", tag), busy, 1'b0);
    chk1($sformatf("%s_abort_status", tag), mmem_status, 1'b0);
    for (int k = 0; k < int'(LAT); k++) begin
      tick();
      chk1($sformatf("%s_post_status", tag), mmem_status, 1'b0);
    end
  endtask

  // Reset pulsed between edges n cycles after acceptance.
  task automatic reset_txn(input int op, input logic [31:0] a, input logic [31:0] d,
                           input int n, input string tag);
    mmem_r = (op == 0); mmem_w = (op != 0);
    mmem_addr = a; mmem_wdata = d;
    tick();
    for (int k = 0; k < n; k++) tick();
    if (n == int'(LAT)) chk1($sformatf("%s_pre_status", tag), mmem_status, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1($sformatf("%s_rst_busy", tag), busy, 1'b0);
    chk1($sformatf("%s_rst_status", tag), mmem_status, 1'b0);
    chk($sformatf("%s_rst_rdata", tag), mmem_rdata, 32'h0);
    mmem_r = 1'b0; mmem_w = 1'b0;
    #1 rst = 1'b0;
    for (int k = 0; k <= int'(LAT); k++) begin
      tick();
      chk1($sformatf("%s_post_status", tag), mmem_status, 1'b0);
      chk1($sformatf("%s_post_busy", tag), busy, 1'b0);
    end
  endtask

  task automatic txn1(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string tag);
    r1 = ~wr; w1 = wr; addr1 = a; wdata1 = d;
    tick();
    chk1($sformatf("%s_acc_status", tag), status1, 1'b0);
    chk1($sformatf("%s_acc_busy", tag), busy1, 1'b1);
    tick();
    chk1($sformatf("%s_status", tag), status1, 1'b1);
    chk($sformatf("%s_rdata", tag), rdata1, exp_rd);
    r1 = 1'b0; w1 = 1'b0;
    tick();
    chk1($sformatf("%s_release", tag), status1, 1'b0);
    tick();
    chk1($sformatf("%s_idle", tag), busy1, 1'b0);
  endtask

  initial begin
    int op;
    logic [31:0] a;
    logic [31:0] d;

    #1;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_status", mmem_status, 1'b0);
    chk("reset_rdata", mmem_rdata, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    txn(1, 32'h0000000C, 32'hDEADBEEF, 0, "preload");
    txn(0, 32'h0000000C, 32'h0, 3, "read_lat");

    txn(1, 32'h00000010, 32'h12345678, 0, "wr10");
    txn(0, 32'h00000010, 32'h0, 0, "rd10");

    abort_txn(0, 32'h0000000C, 32'h0, "abort_rd");
    abort_txn(1, 32'h00000010, 32'hFFFF0000, "abort_wr");
    txn(0, 32'h00000010, 32'h0, 0, "rd10_after_abort");

    txn(2, 32'h00001004, 32'hA5A5A5A5, 0, "both_wrap");
    txn(0, 32'h00000004, 32'h0, 0, "rd4_wrap");

    reset_txn(1, 32'h0000000C, 32'h01010101, 1, "rst_wait_wr");
    txn(0, 32'h0000000C, 32'h0, 0, "rdC_after_rst");
    reset_txn(0, 32'h00000010, 32'h0, int'(LAT), "rst_done_rd");
    txn(0, 32'h00000010, 32'h0, 10, "held10");

    txn1(1'b1, 32'h00000044, 32'hCAFEF00D, 32'h0, "lat1_wr");
    txn1(1'b0, 32'h00000004, 32'h0, 32'hCAFEF00D, "lat1_rd");

    for (int j = 0; j < 16; j++)
      txn(1, 32'(j * 61 * 4), $urandom, 0, "pool_init");

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      a  = ($urandom & 32'hFFFF_F000) | 32'(($urandom_range(0, 15) * 61) << 2) | ($urandom & 32'h3);
      d  = $urandom;
      if (op == 3) abort_txn(int'($urandom_range(0, 1)), a, d, "rand_abort");
      else         txn(op, a, d, int'($urandom_range(0, 3)), "rand");
    end

    for (int j = 0; j < 16; j++)
      txn(0, 32'(j * 61 * 4), 32'h0, 0, "pool_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
